// File: rtl/mem_responder.sv
// mem_responder: multi-cycle word-addressed data memory for the load/store unit.
// Accepts one read or write strobe while idle, completes it after a fixed
// latency and reports completion with a one-cycle status pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   address      byte address; word index is address[ADDR_W+1:2]
//   writeData    store data, latched when a write is accepted
//   nRD, nWR     active-low one-cycle request strobes (read wins if both low)
//   Dataout      registered load data, held until the next read completes
//   readStatus   one-cycle pulse: read complete, Dataout valid
//   writeStatus  one-cycle pulse: write committed
//   busy         high while an access is in flight
module mem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned READ_LAT  = 2,
   parameter int unsigned WRITE_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        nRD,
   input  logic        nWR,
   output logic [31:0] Dataout,
   output logic        readStatus,
   output logic        writeStatus,
   output logic        busy
);

   // Latencies are limited to 1..15, so a 4-bit down-counter suffices.
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [ADDR_W-1:0]   idx, idx_nxt;
   logic [DATA_W-1:0]   wdata, wdata_nxt;
   logic                rd_done_c;
   logic                wr_done_c;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Byte-offset bits and bits above the word index do not take part in decode.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};

   // Next-state, counter and capture logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      wdata_nxt = wdata;
      rd_done_c = 1'b0;
      wr_done_c = 1'b0;
      case (state)
         IDLE: begin
            if (!nRD) begin
               state_nxt = RD_WAIT;
               cnt_nxt   = CNT_W'(READ_LAT - 1);
               idx_nxt   = address[ADDR_W+1:2];
            end else if (!nWR) begin
               state_nxt = WR_WAIT;
               cnt_nxt   = CNT_W'(WRITE_LAT - 1);
               idx_nxt   = address[ADDR_W+1:2];
               wdata_nxt = writeData;
            end
         end
         RD_WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               rd_done_c = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR_WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               wr_done_c = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         wdata       <= '0;
         Dataout     <= '0;
         readStatus  <= 1'b0;
         writeStatus <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         wdata       <= wdata_nxt;
         readStatus  <= rd_done_c;
         writeStatus <= wr_done_c;
         busy        <= (state_nxt != IDLE);
         if (rd_done_c) begin
            Dataout <= mem[idx];
         end
      end
   end

   // Storage is not reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (wr_done_c && !rst) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases followed by randomized
// transactions compared against a transaction-level memory model.
module tb_mem_responder;

   localparam int unsigned RL = 3;
   localparam int unsigned WL = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        nRD;
   logic        nWR;
   logic [31:0] Dataout;
   logic        readStatus;
   logic        writeStatus;
   logic        busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] model_mem [256];
   logic [31:0] model_dout;

   mem_responder #(
      .DEPTH(256), .ADDR_W(8), .READ_LAT(RL), .WRITE_LAT(WL)
   ) dut (
      .clk(clk), .rst(rst), .address(address), .writeData(writeData),
      .nRD(nRD), .nWR(nWR), .Dataout(Dataout), .readStatus(readStatus),
      .writeStatus(writeStatus), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      nRD = 1'b1;
      nWR = 1'b1;
      repeat (n) begin
         tick();
         chk("idle_rs", 32'(readStatus), 32'(0));
         chk("idle_ws", 32'(writeStatus), 32'(0));
         chk("idle_busy", 32'(busy), 32'(0));
         chk("idle_dout", Dataout, model_dout);
      end
   endtask

   // One request; noise drives random strobes while busy, which must be ignored.
   task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit noise);
      int unsigned lat;
      int unsigned wi;
      wi        = int'(addr[9:2]);
      nRD       = !rd;
      nWR       = !wr;
      address   = addr;
      writeData = data;
      tick();
      nRD       = 1'b1;
      nWR       = 1'b1;
      address   = $urandom;
      writeData = $urandom;
      if (!rd && !wr) begin
         chk("noreq_busy", 32'(busy), 32'(0));
         return;
      end
      lat = rd ? RL : WL;
      chk("acc_busy", 32'(busy), 32'(1));
      chk("acc_rs", 32'(readStatus), 32'(0));
      chk("acc_ws", 32'(writeStatus), 32'(0));
      for (int j = 1; j <= int'(lat); j++) begin
         if (noise && ($urandom_range(0, 1) == 1)) begin
            nRD       = ($urandom_range(0, 1) == 1);
            nWR       = ($urandom_range(0, 1) == 1);
            address   = $urandom;
            writeData = $urandom;
         end
         tick();
         nRD = 1'b1;
         nWR = 1'b1;
         if (j < int'(lat)) begin
            chk("wait_busy", 32'(busy), 32'(1));
            chk("wait_rs", 32'(readStatus), 32'(0));
            chk("wait_ws", 32'(writeStatus), 32'(0));
         end
      end
      if (rd) begin
         model_dout = model_mem[wi];
         chk("rd_rs", 32'(readStatus), 32'(1));
         chk("rd_ws", 32'(writeStatus), 32'(0));
      end else begin
         model_mem[wi] = data;
         chk("wr_ws", 32'(writeStatus), 32'(1));
         chk("wr_rs", 32'(readStatus), 32'(0));
      end
      chk("done_busy", 32'(busy), 32'(0));
      chk("done_dout", Dataout, model_dout);
   endtask

   // Request followed by reset inside its wait window: no pulse, no commit.
   task automatic abort_access(input bit rd, input logic [31:0] addr, input logic [31:0] data);
      int unsigned lat;
      int unsigned k;
      lat       = rd ? RL : WL;
      nRD       = !rd;
      nWR       = rd;
      address   = addr;
      writeData = data;
      tick();
      nRD = 1'b1;
      nWR = 1'b1;
      k   = $urandom_range(1, lat);
      repeat (k - 1) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_dout = 32'h0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_rs", 32'(readStatus), 32'(0));
      chk("abort_ws", 32'(writeStatus), 32'(0));
      chk("abort_dout", Dataout, 32'h0);
      idle(RL + 1);
   endtask

   initial begin
      logic [31:0] a;
      int unsigned op;
      rst       = 1'b1;
      nRD       = 1'b1;
      nWR       = 1'b1;
      address   = '0;
      writeData = '0;
      model_dout = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_dout", Dataout, 32'h0);
      chk("rst_rs", 32'(readStatus), 32'(0));
      chk("rst_ws", 32'(writeStatus), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));

      // Fill every word so later reads have a known expected value.
      for (int i = 0; i < 256; i++) begin
         a = $urandom;
         a[9:2] = 8'(i);
         access(1'b0, 1'b1, a, $urandom, 1'b0);
      end

      // Directed cases.
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      chk("dir_rd_dead", Dataout, 32'hDEADBEEF);
      idle(10);
      access(1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0);
      access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("dir_wrap", Dataout, 32'h12345678);
      access(1'b1, 1'b1, 32'h20, 32'h1, 1'b0);
      access(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
      access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      abort_access(1'b0, 32'h44, 32'hA5A5A5A5);
      access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);

      // Randomized mix of reads, writes, collisions, gaps and aborts.
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 9);
         a  = $urandom;
         if (op <= 2)      access(1'b1, 1'b0, a, 32'h0, ($urandom_range(0, 1) == 1));
         else if (op <= 5) access(1'b0, 1'b1, a, $urandom, ($urandom_range(0, 1) == 1));
         else if (op == 6) access(1'b1, 1'b1, a, $urandom, 1'b0);
         else if (op == 7) idle(int'($urandom_range(1, 3)));
         else if (op == 8) abort_access(($urandom_range(0, 1) == 1), a, $urandom);
         else              access(1'b0, 1'b0, a, $urandom, 1'b0);
      end

      // Sweep every word to catch stray or missing commits.
      for (int i = 0; i < 256; i++) begin
         a = $urandom;
         a[9:2] = 8'(i);
         access(1'b1, 1'b0, a, 32'h0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
